// File: rtl/pc_seq_pkg.sv
// Shared types and constants for the program-counter sequencer.
package pc_seq_pkg;

    localparam int PC_W = 16;
    localparam logic [PC_W-1:0] DEFAULT_RESET_VEC = 16'h0000;

    typedef enum logic [1:0] {
        BOOT  = 2'd0,
        FETCH = 2'd1,
        WAIT  = 2'd2,
        HALT  = 2'd3
    } pc_state_t;

endpackage

// File: rtl/pc_sequencer_if.sv
// Fetch handshake plus the retire-time control bundle from decode.
// master = sequencer side, slave = instruction memory / decode side.
interface pc_sequencer_if;
    import pc_seq_pkg::*;

    logic            imem_req;
    logic [PC_W-1:0] imem_addr;
    logic            imem_ready;
    logic            jbp_enable;
    logic [PC_W-1:0] jb_target;
    logic            call;
    logic            ret;
    logic            halt_req;

    modport master (
        output imem_req, imem_addr,
        input  imem_ready, jbp_enable, jb_target, call, ret, halt_req
    );

    modport slave (
        input  imem_req, imem_addr,
        output imem_ready, jbp_enable, jb_target, call, ret, halt_req
    );
endinterface

// File: rtl/pc_ras.sv
// Circular return-address stack; push onto full overwrites the oldest entry.
// Latency: top is combinational from storage, updates one cycle after push/pop.
// Backpressure: none; pop on empty is ignored, push+pop in one cycle is pop only.
module pc_ras #(
    parameter int DEPTH = 4,
    parameter int W     = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         push,
    input  logic         pop,
    input  logic [W-1:0] push_dat,
    output logic [W-1:0] top,
    output logic         empty,
    output logic         full
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam logic [PTR_W-1:0] LAST = PTR_W'(DEPTH - 1);
    localparam logic [CNT_W-1:0] MAX  = CNT_W'(DEPTH);

    logic [W-1:0]     mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] ptr_inc;
    logic [PTR_W-1:0] ptr_dec;
    logic [CNT_W-1:0] count;
    logic             do_pop;
    logic             do_push;

    // wr_ptr is the next free slot; once full it also marks the oldest entry
    assign ptr_inc = (wr_ptr == LAST)  ? '0   : wr_ptr + 1'b1;
    assign ptr_dec = (wr_ptr == '0)    ? LAST : wr_ptr - 1'b1;
    assign top     = mem[ptr_dec];
    assign empty   = (count == '0);
    assign full    = (count == MAX);
    assign do_pop  = pop && !empty;
    assign do_push = push && !pop;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            count  <= '0;
        end else if (do_pop) begin
            wr_ptr <= ptr_dec;
            count  <= count - 1'b1;
        end else if (do_push) begin
            wr_ptr <= ptr_inc;
            if (!full) begin
                count <= count + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_dat;
        end
    end
endmodule

// File: rtl/pc_sequencer.sv
// PC register, fetch FSM and next-PC mux (PC+2 / jump / RAS pop); RAS built only with PC_RAS_EN.
// Latency: new pc visible the cycle after the retiring edge; one instruction per cycle at full ready.
// Backpressure: imem_ready low parks in WAIT with imem_addr held; imem_req depends on state only.
module pc_sequencer
    import pc_seq_pkg::*;
#(
    parameter logic [PC_W-1:0] RESET_VEC = DEFAULT_RESET_VEC,
    parameter int              RAS_DEPTH = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    pc_sequencer_if.master        bus,
    output logic [PC_W-1:0]       pc,
    output logic [PC_W-1:0]       pc_plus2,
    output logic [1:0]            state,
    output logic                  ras_underflow
);
    if (RAS_DEPTH < 2 || RAS_DEPTH > 8) begin : g_bad_depth
        $error("pc_sequencer: RAS_DEPTH must be in 2..8");
    end
    if (RESET_VEC[0] != 1'b0) begin : g_bad_vec
        $error("pc_sequencer: RESET_VEC must be 2-byte aligned");
    end

    pc_state_t       state_q;
    pc_state_t       state_d;
    logic [PC_W-1:0] pc_q;
    logic [PC_W-1:0] pc_d;
    logic            retire;
    logic            active;
    logic [PC_W-1:0] jump_pc;
    logic            pop_taken;
    logic [PC_W-1:0] pop_pc;
    logic            underflow_d;
    logic            underflow_q;

    assign active   = (state_q == FETCH) || (state_q == WAIT);
    assign retire   = active && bus.imem_ready;
    assign pc_plus2 = pc_q + 16'd2;
    assign jump_pc  = {bus.jb_target[PC_W-1:1], 1'b0};

`ifdef PC_RAS_EN
    logic ras_empty;
    logic ras_full;
    logic ras_push;
    logic ras_pop;
    logic unused_jb_lsb;

    assign unused_jb_lsb = bus.jb_target[0] ^ ras_full;

    // A retiring ret always suppresses the push, even if the stack turns out empty
    assign ras_pop     = retire && bus.ret;
    assign ras_push    = retire && bus.call && !bus.ret;
    assign pop_taken   = ras_pop && !ras_empty;
    assign underflow_d = ras_pop && ras_empty;

    pc_ras #(
        .DEPTH (RAS_DEPTH),
        .W     (PC_W)
    ) u_ras (
        .clk      (clk),
        .rst      (rst),
        .push     (ras_push),
        .pop      (ras_pop),
        .push_dat (pc_plus2),
        .top      (pop_pc),
        .empty    (ras_empty),
        .full     (ras_full)
    );
`else
    logic unused_ras_inputs;

    assign unused_ras_inputs = ^{bus.call, bus.ret, bus.jb_target[0]};
    assign pop_taken         = 1'b0;
    assign pop_pc            = '0;
    assign underflow_d       = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        unique case (state_q)
            BOOT:  state_d = FETCH;
            FETCH,
            WAIT: begin
                if (!bus.imem_ready) begin
                    state_d = WAIT;
                end else if (bus.halt_req) begin
                    state_d = HALT;
                end else begin
                    state_d = FETCH;
                end
            end
            HALT:  state_d = HALT;
            default: state_d = BOOT;
        endcase

        if (retire) begin
            if (pop_taken) begin
                pc_d = pop_pc;
            end else if (bus.jbp_enable) begin
                pc_d = jump_pc;
            end else begin
                pc_d = pc_plus2;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= BOOT;
            pc_q        <= RESET_VEC;
            underflow_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            underflow_q <= underflow_d;
        end
    end

    assign pc            = pc_q;
    assign state         = state_q;
    assign ras_underflow = underflow_q;
    assign bus.imem_req  = active;
    assign bus.imem_addr = pc_q;
endmodule

// File: tb/tb_pc_sequencer.sv
// Directed-vector bench for pc_sequencer; RAS scenarios compile in only when PC_RAS_EN is defined.
module tb_pc_sequencer;
    logic        clk;
    logic        rst;
    logic [15:0] pc;
    logic [15:0] pc_plus2;
    logic [1:0]  state;
    logic        ras_underflow;
    int          passed;
    int          total;

    pc_sequencer_if bus();

    pc_sequencer #(.RESET_VEC(16'h0000), .RAS_DEPTH(4)) dut (
        .clk           (clk),
        .rst           (rst),
        .bus           (bus.master),
        .pc            (pc),
        .pc_plus2      (pc_plus2),
        .state         (state),
        .ras_underflow (ras_underflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus.imem_ready = 1'b0;
        bus.jbp_enable = 1'b0;
        bus.jb_target  = 16'h0000;
        bus.call       = 1'b0;
        bus.ret        = 1'b0;
        bus.halt_req   = 1'b0;
    endtask

    // one retiring jump, used to place pc at a chosen address
    task automatic jump_to(input logic [15:0] tgt);
        bus.imem_ready = 1'b1;
        bus.jbp_enable = 1'b1;
        bus.jb_target  = tgt;
        tick();
        bus.jbp_enable = 1'b0;
    endtask

    task automatic test_reset();
        idle_inputs();
        rst = 1'b1;
        tick();
        tick();
        total++; if (pc !== 16'h0000) $display("FAIL reset_pc got %h want 0000", pc); else passed++;
        total++; if (state !== 2'd0) $display("FAIL reset_state got %0d want 0", state); else passed++;
        total++; if (bus.imem_req !== 1'b0) $display("FAIL reset_req got %b want 0", bus.imem_req); else passed++;
        total++; if (ras_underflow !== 1'b0) $display("FAIL reset_uf got %b want 0", ras_underflow); else passed++;
        total++; if (pc_plus2 !== 16'h0002) $display("FAIL reset_pcp2 got %h want 0002", pc_plus2); else passed++;
        // inputs during BOOT must not retire
        rst = 1'b0;
        bus.imem_ready = 1'b1;
        bus.jbp_enable = 1'b1;
        bus.jb_target  = 16'h5554;
        tick();
        total++; if (state !== 2'd1) $display("FAIL boot_exit_state got %0d want 1", state); else passed++;
        total++; if (pc !== 16'h0000) $display("FAIL boot_ignore_pc got %h want 0000", pc); else passed++;
        total++; if (bus.imem_req !== 1'b1) $display("FAIL first_req got %b want 1", bus.imem_req); else passed++;
        bus.jbp_enable = 1'b0;
    endtask

    task automatic test_sequential();
        logic [15:0] want;
        bus.imem_ready = 1'b1;
        want = 16'h0000;
        for (int i = 0; i < 4; i++) begin
            tick();
            want = want + 16'h0002;
            total++; if (pc !== want) $display("FAIL seq_pc[%0d] got %h want %h", i, pc, want); else passed++;
            total++; if (bus.imem_addr !== want) $display("FAIL seq_addr[%0d] got %h want %h", i, bus.imem_addr, want); else passed++;
        end
    endtask

    task automatic test_wait();
        jump_to(16'h0010);
        total++; if (pc !== 16'h0010) $display("FAIL wait_setup got %h want 0010", pc); else passed++;
        bus.imem_ready = 1'b0;
        bus.jbp_enable = 1'b1;
        bus.jb_target  = 16'h7776;
        for (int i = 0; i < 3; i++) begin
            tick();
            total++; if (state !== 2'd2) $display("FAIL wait_state[%0d] got %0d want 2", i, state); else passed++;
            total++; if (bus.imem_addr !== 16'h0010) $display("FAIL wait_addr[%0d] got %h want 0010", i, bus.imem_addr); else passed++;
            total++; if (bus.imem_req !== 1'b1) $display("FAIL wait_req[%0d] got %b want 1", i, bus.imem_req); else passed++;
        end
        bus.jbp_enable = 1'b0;
        bus.imem_ready = 1'b1;
        tick();
        total++; if (pc !== 16'h0012) $display("FAIL wait_release_pc got %h want 0012", pc); else passed++;
        total++; if (state !== 2'd1) $display("FAIL wait_release_state got %0d want 1", state); else passed++;
    endtask

    task automatic test_jump_wrap();
        jump_to(16'h1235);
        total++; if (pc !== 16'h1234) $display("FAIL jump_align got %h want 1234", pc); else passed++;
        jump_to(16'hFFFE);
        total++; if (pc_plus2 !== 16'h0000) $display("FAIL wrap_pcp2 got %h want 0000", pc_plus2); else passed++;
        tick();
        total++; if (pc !== 16'h0000) $display("FAIL wrap_pc got %h want 0000", pc); else passed++;
    endtask

`ifdef PC_RAS_EN
    task automatic test_ras();
        logic [15:0] want_pc [5];
        jump_to(16'h0100);
        bus.call = 1'b1;
        jump_to(16'h0400);
        bus.call = 1'b0;
        total++; if (pc !== 16'h0400) $display("FAIL call_pc got %h want 0400", pc); else passed++;
        bus.ret = 1'b1;
        tick();
        bus.ret = 1'b0;
        total++; if (pc !== 16'h0102) $display("FAIL ret_pc got %h want 0102", pc); else passed++;
        // five nested calls on a 4-deep stack: 0x1002 is overwritten
        jump_to(16'h1000);
        bus.call = 1'b1;
        for (int i = 1; i <= 5; i++) begin
            jump_to(16'h1000 * (i + 1));
        end
        bus.call = 1'b0;
        total++; if (pc !== 16'h6000) $display("FAIL nest_pc got %h want 6000", pc); else passed++;
        want_pc[0] = 16'h5002;
        want_pc[1] = 16'h4002;
        want_pc[2] = 16'h3002;
        want_pc[3] = 16'h2002;
        want_pc[4] = 16'h2004;
        bus.ret = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            total++; if (pc !== want_pc[i]) $display("FAIL ret_chain_pc[%0d] got %h want %h", i, pc, want_pc[i]); else passed++;
            total++; if (ras_underflow !== (i == 4)) $display("FAIL ret_chain_uf[%0d] got %b want %b", i, ras_underflow, (i == 4)); else passed++;
        end
        bus.ret = 1'b0;
        tick();
        total++; if (ras_underflow !== 1'b0) $display("FAIL uf_pulse_end got %b want 0", ras_underflow); else passed++;
    endtask
`else
    task automatic test_ras_disabled();
        jump_to(16'h0100);
        bus.call = 1'b1;
        jump_to(16'h0400);
        bus.call = 1'b0;
        total++; if (pc !== 16'h0400) $display("FAIL call_pc got %h want 0400", pc); else passed++;
        bus.ret = 1'b1;
        tick();
        bus.ret = 1'b0;
        total++; if (pc !== 16'h0402) $display("FAIL ret_ignored_pc got %h want 0402", pc); else passed++;
        total++; if (ras_underflow !== 1'b0) $display("FAIL ret_ignored_uf got %b want 0", ras_underflow); else passed++;
        tick();
        total++; if (ras_underflow !== 1'b0) $display("FAIL ret_ignored_uf2 got %b want 0", ras_underflow); else passed++;
    endtask
`endif

    task automatic test_halt();
        jump_to(16'h0020);
        bus.halt_req = 1'b1;
        tick();
        bus.halt_req = 1'b0;
        total++; if (pc !== 16'h0022) $display("FAIL halt_pc got %h want 0022", pc); else passed++;
        total++; if (state !== 2'd3) $display("FAIL halt_state got %0d want 3", state); else passed++;
        total++; if (bus.imem_req !== 1'b0) $display("FAIL halt_req_out got %b want 0", bus.imem_req); else passed++;
        bus.jbp_enable = 1'b1;
        bus.jb_target  = 16'h4444;
        for (int i = 0; i < 4; i++) begin
            bus.imem_ready = (i % 2 == 0);
            tick();
            total++; if (state !== 2'd3 || pc !== 16'h0022) $display("FAIL halt_hold[%0d] got state %0d pc %h want 3 0022", i, state, pc); else passed++;
        end
        bus.jbp_enable = 1'b0;
    endtask

    task automatic test_reset_in_wait();
        idle_inputs();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        tick();
        bus.imem_ready = 1'b1;
        tick();
        bus.imem_ready = 1'b0;
        tick();
        total++; if (state !== 2'd2 || pc !== 16'h0002) $display("FAIL prewait got state %0d pc %h want 2 0002", state, pc); else passed++;
        rst = 1'b1;
        #1;
        total++; if (pc !== 16'h0000) $display("FAIL async_rst_pc got %h want 0000", pc); else passed++;
        total++; if (state !== 2'd0) $display("FAIL async_rst_state got %0d want 0", state); else passed++;
        total++; if (bus.imem_req !== 1'b0) $display("FAIL async_rst_req got %b want 0", bus.imem_req); else passed++;
        tick();
        rst = 1'b0;
        bus.imem_ready = 1'b1;
        tick();
        total++; if (state !== 2'd1 || pc !== 16'h0000) $display("FAIL restart_fetch got state %0d pc %h want 1 0000", state, pc); else passed++;
        tick();
        total++; if (pc !== 16'h0002) $display("FAIL restart_step got %h want 0002", pc); else passed++;
    endtask

    initial begin
        passed = 0;
        total  = 0;
        rst    = 1'b1;
        idle_inputs();
        test_reset();
        test_sequential();
        test_wait();
        test_jump_wrap();
`ifdef PC_RAS_EN
        test_ras();
`else
        test_ras_disabled();
`endif
        test_halt();
        test_reset_in_wait();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
